wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port among N_REQ write-back sources (ALU, load unit, mul/div).
//  Round-robin arbitration with a valid/ready handshake per source.
//  Registered write-port outputs drive the enable/address/data of the 32x32 register bank.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  N_REQ   3   number of write-back requesters (2..8)
//  XLEN    32  data width
//  REG_AW  5   register address width
// PORTS
//  clk        in   1             clock
//  rst_l      in   1             reset, asynchronous, active-low
//  req_valid  in   N_REQ         requester i has a write pending
//  req_rd     in   N_REQ*REG_AW  destination reg, slice i = [i*REG_AW +: REG_AW]
//  req_data   in   N_REQ*XLEN    write data, slice i = [i*XLEN +: XLEN]
//  req_ready  out  N_REQ         one-hot (or 0) accept for requester i this cycle
//  port_hold  in   1             write port blocked (e.g. debug access); no grant while high
//  wb_en      out  1             register-file write enable (registered)
//  wb_addr    out  REG_AW        register-file write address (registered)
//  wb_data    out  XLEN          register-file write data (registered)
//  wb_src     out  $clog2(N_REQ) index of requester that produced current wb_* (registered)
//  pend_map   out  2**REG_AW     bit r set: accepted write to reg r not yet visible in wb_*
// BEHAVIOUR
//  - Reset: wb_en=0, wb_addr=0, wb_data=0, wb_src=0, rr_ptr=0, pend_map=0; req_ready=0 while rst_l=0.
//  - Transfer on req_valid[i] & req_ready[i]; requester holds valid/rd/data stable until accepted.
//  - req_ready combinational: at most one bit; zero when port_hold=1 or no valid.
//  - Grant: first valid index scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//  - After a transfer to i, rr_ptr <= (i+1) mod N_REQ; no transfer -> rr_ptr unchanged.
//  - Latency 1: transfer in cycle t -> wb_en=1, wb_addr, wb_data, wb_src valid in cycle t+1.
//  - No transfer in cycle t -> wb_en=0 in t+1; wb_addr/wb_data/wb_src hold previous values.
//  - rd==0: transfer still completes (ready high, rr_ptr advances) but wb_en stays 0 (x0 never written).
//  - pend_map: bit rd set combinationally for the accepted rd; cleared the cycle wb_en writes it.
//    Used by hazard logic; bit 0 never set.
//  - Back-to-back same rd from two sources: both written in grant order, last grant wins.
//  - port_hold rising mid-stream: the write already registered still completes; no new grant.
//  - Async reset mid-transfer: all state cleared immediately; the in-flight write is dropped.
//  - N_REQ not a power of two: rr_ptr wraps at N_REQ-1 -> 0, never holds an illegal index.
// STRUCTURE
//  - Package wb_arb_pkg: XLEN, REG_AW constants; typedef wb_req_t {logic [REG_AW-1:0] rd;
//    logic [XLEN-1:0] data;}; function rr_pick(valid, ptr) returning {found, idx}.
//  - Sub-module rr_arbiter #(N): rr_ptr register + one-hot grant logic; reused by other shared ports.
//  - Top: request mux, x0 filter, output register stage with async reset, pend_map logic.
// TESTING
//  - Reset: hold rst_l=0 with all req_valid=1 -> req_ready=0, wb_en=0, pend_map=0.
//  - Single source: req_valid=001, rd=5, data=0xDEADBEEF -> ready=001; next cycle wb_en=1,
//    wb_addr=5, wb_data=0xDEADBEEF, wb_src=0.
//  - Fairness: all three valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; wb_en=1 every cycle.
//  - x0 drop: source 1 writes rd=0, data=0x1234 -> ready[1]=1, rr_ptr->2, wb_en=0 next cycle.
//  - Hold: port_hold=1 for 3 cycles with valid=111 -> ready=000, wb_en=0;
//    release -> grant resumes at saved rr_ptr.
//  - Async reset mid-stream: rst_l low between clock edges -> wb_en=0 at once;
//    first grant after release goes to source 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants, request type and round-robin pick helper for the write-back arbiter
// and any other shared port that reuses rr_arbiter.
package wb_arb_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int MAX_REQ = 8;
  localparam int PICK_W  = 3;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid scanning ptr, ptr+1, ... modulo n (n in 2..MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [PICK_W-1:0]  ptr,
                                       input int                 n);
    rr_pick_t          res;
    logic [PICK_W-1:0] j;
    res.found = 1'b0;
    res.idx   = {PICK_W{1'b0}};
    // Scan from the far end so the closest candidate to ptr is written last.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      j = PICK_W'((int'(ptr) + k) % n);
      if ((k < n) && valid[j]) begin
        res.found = 1'b1;
        res.idx   = j;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus one-hot grant; the pointer moves past the
// winner only when a grant is issued.
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int  N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic [N-1:0]  req_i,
  input  logic          hold_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [N-1:0]  gnt_s;
  logic [IW-1:0] gnt_idx_s;
  rr_pick_t      pick_s;

  // Grant decode and next pointer; no grant is ever issued while in reset or held.
  always_comb begin
    pick_s    = rr_pick(MAX_REQ'(req_i), PICK_W'(ptr_q), N);
    gnt_s     = {N{1'b0}};
    gnt_idx_s = {IW{1'b0}};
    ptr_d     = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (rst_l && !hold_i && pick_s.found && (pick_s.idx == PICK_W'(i))) begin
        gnt_s[i]  = 1'b1;
        gnt_idx_s = IW'(i);
        ptr_d     = IW'((i + 1) % N);
      end else begin
        gnt_s[i] = 1'b0;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr_q <= {IW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o     = gnt_s;
  assign gnt_idx_o = gnt_idx_s;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among N_REQ write-back sources with round-robin
// arbitration and a registered write stage; writes to x0 are accepted but suppressed.
module wb_port_arbiter #(
  parameter int  N_REQ  = 3,
  parameter int  XLEN   = wb_arb_pkg::XLEN,
  parameter int  REG_AW = wb_arb_pkg::REG_AW,
  localparam int SW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*REG_AW-1:0] req_rd,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    port_hold,
  output logic                    wb_en,
  output logic [REG_AW-1:0]       wb_addr,
  output logic [XLEN-1:0]         wb_data,
  output logic [SW-1:0]           wb_src,
  output logic [2**REG_AW-1:0]    pend_map
);

  logic [N_REQ-1:0]    gnt_s;
  logic [SW-1:0]       gnt_idx_s;
  logic                xfer_s;
  logic                wr_s;
  logic [REG_AW-1:0]   sel_rd_s;
  logic [XLEN-1:0]     sel_data_s;
  logic                wb_en_q;
  logic [REG_AW-1:0]   wb_addr_q;
  logic [XLEN-1:0]     wb_data_q;
  logic [SW-1:0]       wb_src_q;
  logic [2**REG_AW-1:0] pend_s;

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr (
    .clk      (clk),
    .rst_l    (rst_l),
    .req_i    (req_valid),
    .hold_i   (port_hold),
    .gnt_o    (gnt_s),
    .gnt_idx_o(gnt_idx_s)
  );

  assign xfer_s = |gnt_s;

  // Request mux driven by the one-hot grant.
  always_comb begin
    sel_rd_s   = {REG_AW{1'b0}};
    sel_data_s = {XLEN{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_rd_s   = req_rd[i*REG_AW +: REG_AW];
        sel_data_s = req_data[i*XLEN +: XLEN];
      end else begin
        sel_rd_s = sel_rd_s;
      end
    end
  end

  // x0 is never written; such a transfer only consumes the grant.
  assign wr_s = xfer_s && (sel_rd_s != {REG_AW{1'b0}});

  // A write is pending only in its accept cycle, since it is visible in wb_* one cycle later.
  always_comb begin
    pend_s = {(2**REG_AW){1'b0}};
    if (wr_s) begin
      pend_s[sel_rd_s] = 1'b1;
    end else begin
      pend_s = {(2**REG_AW){1'b0}};
    end
  end

  // Output register stage; address/data/source hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= {REG_AW{1'b0}};
      wb_data_q <= {XLEN{1'b0}};
      wb_src_q  <= {SW{1'b0}};
    end else if (xfer_s) begin
      wb_en_q   <= wr_s;
      wb_addr_q <= sel_rd_s;
      wb_data_q <= sel_data_s;
      wb_src_q  <= gnt_idx_s;
    end else begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= wb_addr_q;
      wb_data_q <= wb_data_q;
      wb_src_q  <= wb_src_q;
    end
  end

  assign req_ready = gnt_s;
  assign pend_map  = pend_s;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign wb_src    = wb_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by random traffic,
// all compared against a small round-robin reference model.
module tb_wb_port_arbiter;

  localparam int N = 3;

  logic            clk;
  logic            rst_l;
  logic            port_hold;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_rd;
  logic [N*32-1:0] req_data;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic [1:0]      wb_src;
  logic [31:0]     pend_map;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          ptr;
  logic        exp_en;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          exp_src;
  bit          exp_known;
  bit          busy[N];

  wb_port_arbiter dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .req_valid(req_valid),
    .req_rd   (req_rd),
    .req_data (req_data),
    .req_ready(req_ready),
    .port_hold(port_hold),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_src   (wb_src),
    .pend_map (pend_map)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]       = v;
    req_rd[i*5 +: 5]   = rd;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic model_reset();
    ptr       = 0;
    exp_en    = 1'b0;
    exp_addr  = 5'd0;
    exp_data  = 32'd0;
    exp_src   = 0;
    exp_known = 1'b1;
  endtask

  // One clock: check combinational outputs, advance the model, check the registered outputs.
  task automatic cycle(output int g);
    logic [N-1:0] exp_rdy;
    logic [31:0]  exp_pm;
    logic [4:0]   grd;
    #1;
    g = -1;
    if (!port_hold) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    exp_rdy = '0;
    exp_pm  = '0;
    grd     = 5'd0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      grd = req_rd[g*5 +: 5];
      if (grd != 5'd0) exp_pm[grd] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("pend_map", 64'(pend_map), 64'(exp_pm));
    @(posedge clk);
    if (g >= 0) begin
      ptr       = (g + 1) % N;
      exp_en    = (grd != 5'd0);
      exp_known = (grd != 5'd0);
      exp_addr  = grd;
      exp_data  = req_data[g*32 +: 32];
      exp_src   = g;
    end else begin
      exp_en = 1'b0;
    end
    #1;
    chk("wb_en", 64'(wb_en), 64'(exp_en));
    if (exp_known) begin
      chk("wb_addr", 64'(wb_addr), 64'(exp_addr));
      chk("wb_data", 64'(wb_data), 64'(exp_data));
      chk("wb_src", 64'(wb_src), 64'(exp_src));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  initial begin
    int g;
    rst_l     = 1'b0;
    port_hold = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    model_reset();

    // Reset with every source requesting.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 3), 32'h100 + 32'(i));
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_pend", 64'(pend_map), 64'd0);
    chk("rst_addr", 64'(wb_addr), 64'd0);
    chk("rst_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // Single source.
    req_valid = '0;
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle(g);
    req_valid = '0;
    cycle(g);

    // Fairness from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      cycle(g);
      chk("fair_order", 64'(g), 64'(c % N));
    end

    // x0 write from source 1, then everyone competes.
    req_valid = '0;
    set_req(1, 1'b1, 5'd0, 32'h1234);
    cycle(g);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 10), 32'hB000_0000 + 32'(i));
    cycle(g);
    chk("after_x0_grant", 64'(g), 64'd2);

    // Port hold for three cycles, then release.
    port_hold = 1'b1;
    for (int c = 0; c < 3; c++) cycle(g);
    port_hold = 1'b0;
    cycle(g);
    cycle(g);

    // Same destination from two sources back to back.
    req_valid = '0;
    set_req(0, 1'b1, 5'd7, 32'h0000_0007);
    set_req(1, 1'b1, 5'd7, 32'h0000_0070);
    cycle(g);
    cycle(g);
    req_valid = '0;
    cycle(g);

    // Asynchronous reset between clock edges with a write in flight.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 20), 32'hC000_0000 + 32'(i));
    cycle(g);
    @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    chk("arst_wb_en", 64'(wb_en), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_pend", 64'(pend_map), 64'd0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    cycle(g);
    chk("arst_first_grant", 64'(g), 64'd0);

    // Random traffic; sources keep their request stable until accepted.
    req_valid = '0;
    for (int i = 0; i < N; i++) busy[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!busy[i]) begin
          logic [4:0] r;
          r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          if ($urandom_range(0, 9) < 6) begin
            set_req(i, 1'b1, r, $urandom);
            busy[i] = 1'b1;
          end else begin
            set_req(i, 1'b0, r, $urandom);
          end
        end
      end
      port_hold = ($urandom_range(0, 4) == 0);
      cycle(g);
      if (g >= 0) busy[g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
